// File: rtl/spi_txn_arbiter_if.sv
// Bundle between the SPI transaction arbiter, its requesters and the byte-level
// SPI master. The slave modport is the arbiter's view; master is the view of the
// environment that drives requests and models the SPI master.
interface spi_txn_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_cmd;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          err;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          m_load;
  logic [DATA_WIDTH-1:0]         m_data;
  logic                          m_busy;
  logic                          m_done;
  logic [DATA_WIDTH-1:0]         m_rx;
  logic                          m_ssb;

  modport slave (
    input  req, req_cmd, req_data, m_busy, m_done, m_rx,
    output gnt, done, err, rd_data, m_load, m_data, m_ssb
  );

  modport master (
    output req, req_cmd, req_data, m_busy, m_done, m_rx,
    input  gnt, done, err, rd_data, m_load, m_data, m_ssb
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one byte-level SPI master between NUM_REQ requesters.
// Each granted transaction sends a command byte then a data byte inside one SSB-low
// frame and returns the MISO byte captured during the data byte.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no frame; pick next requester round-robin from r_ptr
// S_CMD_LOAD  | SSB low, waiting for master idle to load the command byte
// S_CMD_WAIT  | command byte shifting; MISO discarded; timeout armed
// S_DATA_LOAD | waiting for master idle to load the data byte
// S_DATA_WAIT | data byte shifting; MISO captured on m_done; timeout armed
// S_FINISH    | SSB high, done (and err on timeout) pulse to the grantee
// S_GAP       | SSB held high GAP_CYCLES cycles; requests ignored
module spi_txn_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             reset,
  spi_txn_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_LOAD,
    S_CMD_WAIT,
    S_DATA_LOAD,
    S_DATA_WAIT,
    S_FINISH,
    S_GAP
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_ssb;
  logic [DATA_WIDTH-1:0] r_data;
  logic [TO_W-1:0]       r_to_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;

  logic                  w_any;
  logic [PTR_W-1:0]      w_winner;
  logic [PTR_W-1:0]      w_ptr_next;
  logic [NUM_REQ-1:0]    w_onehot;
  logic [DATA_WIDTH-1:0] w_cmd_sel;
  logic [DATA_WIDTH-1:0] w_data_sel;
  logic                  w_m_load;

  // Round-robin search from r_ptr, then select the winner's one-hot grant and byte slices
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    w_any      = 1'b0;
    w_winner   = '0;
    w_onehot   = '0;
    w_cmd_sel  = '0;
    w_data_sel = '0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, r_ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
        sum = sum - (PTR_W + 1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!w_any && bus.req[idx]) begin
        w_any    = 1'b1;
        w_winner = idx;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_winner == PTR_W'(k)) begin
        w_onehot[k] = 1'b1;
        w_cmd_sel   = bus.req_cmd[k*DATA_WIDTH +: DATA_WIDTH];
        w_data_sel  = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_ptr_next = (w_winner == PTR_LAST) ? '0 : w_winner + 1'b1;

  // The load strobe reacts to m_busy in the same cycle so a byte goes out the cycle busy falls
  assign w_m_load = ((r_state == S_CMD_LOAD) || (r_state == S_DATA_LOAD)) && !bus.m_busy;

  // Transaction sequencer: grant, byte loading, per-byte timeout, completion and gap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      r_m_data  <= '0;
      r_m_ssb   <= 1'b1;
      r_data    <= '0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt    <= w_onehot;
            r_m_data <= w_cmd_sel;
            r_data   <= w_data_sel;
            r_m_ssb  <= 1'b0;
            r_ptr    <= w_ptr_next;
            r_state  <= S_CMD_LOAD;
          end
        end
        S_CMD_LOAD: begin
          if (w_m_load) begin
            r_to_cnt <= '0;
            r_state  <= S_CMD_WAIT;
          end
        end
        S_CMD_WAIT: begin
          // m_done beats the timeout when both land in the same cycle
          if (bus.m_done) begin
            r_m_data <= r_data;
            r_state  <= S_DATA_LOAD;
          end else if (r_to_cnt == TO_LAST) begin
            r_rd_data <= '0;
            r_done    <= r_gnt;
            r_err     <= 1'b1;
            r_m_ssb   <= 1'b1;
            r_state   <= S_FINISH;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_DATA_LOAD: begin
          if (w_m_load) begin
            r_to_cnt <= '0;
            r_state  <= S_DATA_WAIT;
          end
        end
        S_DATA_WAIT: begin
          if (bus.m_done) begin
            r_rd_data <= bus.m_rx;
            r_done    <= r_gnt;
            r_err     <= 1'b0;
            r_m_ssb   <= 1'b1;
            r_state   <= S_FINISH;
          end else if (r_to_cnt == TO_LAST) begin
            r_rd_data <= '0;
            r_done    <= r_gnt;
            r_err     <= 1'b1;
            r_m_ssb   <= 1'b1;
            r_state   <= S_FINISH;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_FINISH: begin
          r_done    <= '0;
          r_err     <= 1'b0;
          r_gnt     <= '0;
          r_gap_cnt <= GAP_LAST;
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.rd_data = r_rd_data;
  assign bus.m_load  = w_m_load;
  assign bus.m_data  = r_m_data;
  assign bus.m_ssb   = r_m_ssb;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: a behavioural SPI master answers each loaded
// byte after a programmable latency; the stimulus block walks single transfer,
// round-robin, busy stall, timeout and reset scenarios with hand-computed results.
module tb_spi_txn_arbiter;
  localparam int NR = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;

  spi_txn_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  spi_txn_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .GAP_CYCLES(2),
    .TIMEOUT   (64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  int         lat    = 3;
  logic       silent = 1'b0;
  logic [7:0] rx_val = 8'h00;

  logic [7:0] load_log [0:63];
  int n_loads  = 0;
  int n_frames = 0;
  int n_done   = 0;
  int n_viol   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.done == '0 && n < max_cyc);
    chk("done_seen", 32'(bus.done != '0), 1);
  endtask

  // Behavioural SPI master: answers each loaded byte after lat cycles
  initial begin : master_model
    logic       lv, ssb_s, ssb_prev, rs, is_data;
    logic [7:0] md;
    int         cd, bcnt;
    bus.m_done = 1'b0;
    bus.m_rx   = 8'h00;
    cd = 0; bcnt = 0; ssb_prev = 1'b1; is_data = 1'b0;
    forever begin
      @(posedge clk);
      lv = bus.m_load; md = bus.m_data; ssb_s = bus.m_ssb; rs = reset;
      if (!rs && bus.done != '0) begin
        n_done++;
        if ($countones(bus.done) != 1 || (bus.done & ~bus.gnt) != '0) n_viol++;
      end
      #1;
      bus.m_done = 1'b0;
      if (rs) begin
        cd = 0; bcnt = 0;
      end else begin
        if (ssb_prev && !ssb_s) n_frames++;
        if (ssb_s) bcnt = 0;
        if (lv) begin
          load_log[n_loads[5:0]] = md;
          n_loads++;
          is_data = (bcnt == 1);
          bcnt++;
          cd = (silent && !is_data) ? 0 : lat;
        end else if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.m_done = 1'b1;
            bus.m_rx   = is_data ? rx_val : 8'h5A;
          end
        end
      end
      ssb_prev = ssb_s;
    end
  end

  initial begin : stimulus
    int         n, k, base, pulses;
    logic       ok;
    logic [7:0] exp_t2  [0:7];
    logic [1:0] exp_gnt [0:3];
    exp_t2  = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h10, 8'h20, 8'h11, 8'h21};
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};

    reset = 1'b1;
    bus.req = '0; bus.req_cmd = '0; bus.req_data = '0; bus.m_busy = 1'b0;
    repeat (3) tick();
    chk("rst_gnt",     32'(bus.gnt), 0);
    chk("rst_done",    32'(bus.done), 0);
    chk("rst_err",     32'(bus.err), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_m_load",  32'(bus.m_load), 0);
    chk("rst_m_data",  32'(bus.m_data), 0);
    chk("rst_m_ssb",   32'(bus.m_ssb), 1);
    reset = 1'b0;
    tick();

    // T1 single transaction from requester 0
    bus.req_cmd = {8'h00, 8'h01}; bus.req_data = {8'h00, 8'h22};
    rx_val = 8'hA5; lat = 3;
    bus.req = 2'b01;
    tick();
    chk("t1_gnt",      32'(bus.gnt), 1);
    chk("t1_ssb_low",  32'(bus.m_ssb), 0);
    chk("t1_m_load",   32'(bus.m_load), 1);
    chk("t1_m_data",   32'(bus.m_data), 'h01);
    wait_done(100, n);
    chk("t1_done",     32'(bus.done), 1);
    chk("t1_err",      32'(bus.err), 0);
    chk("t1_rd_data",  32'(bus.rd_data), 'hA5);
    chk("t1_ssb_high", 32'(bus.m_ssb), 1);
    bus.req = '0;
    chk("t1_n_loads",  n_loads, 2);
    chk("t1_cmd_byte", 32'(load_log[0]), 'h01);
    chk("t1_dat_byte", 32'(load_log[1]), 'h22);
    chk("t1_frames",   n_frames, 1);
    tick();
    chk("t1_done_1cyc", 32'(bus.done), 0);
    chk("t1_gnt_clr",   32'(bus.gnt), 0);

    // T2 round-robin with both requesters held
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_cmd = {8'h11, 8'h10}; bus.req_data = {8'h21, 8'h20};
    rx_val = 8'h5C; base = n_loads;
    bus.req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_done(200, n);
      chk("t2_done_order", 32'(bus.done), 32'(exp_gnt[f]));
      chk("t2_rd_data",    32'(bus.rd_data), 'h5C);
      if (f == 3) begin
        bus.req = '0;
      end else begin
        k = 0; ok = 1'b1;
        do begin
          tick();
          k++;
          if (bus.gnt == '0 && bus.m_ssb !== 1'b1) ok = 1'b0;
        end while (bus.gnt == '0 && k < 20);
        chk("t2_gap_len",  k, 4);
        chk("t2_gap_ssb",  32'(ok), 1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      chk("t2_load_seq", 32'(load_log[6'(base + i)]), 32'(exp_t2[i]));
    end

    // T3 master busy stalls the command load
    repeat (4) tick();
    bus.req_cmd = {8'h00, 8'h33}; bus.req_data = {8'h00, 8'h44};
    rx_val = 8'h3E; base = n_loads;
    bus.m_busy = 1'b1;
    bus.req = 2'b01;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.m_load !== 1'b0 || bus.m_ssb !== 1'b0) ok = 1'b0;
    end
    chk("t3_load_held", 32'(ok), 1);
    chk("t3_no_load",   n_loads - base, 0);
    bus.m_busy = 1'b0;
    #1;
    chk("t3_load_on_fall", 32'(bus.m_load), 1);
    chk("t3_m_data",       32'(bus.m_data), 'h33);
    wait_done(100, n);
    chk("t3_done",     32'(bus.done), 1);
    chk("t3_rd_data",  32'(bus.rd_data), 'h3E);
    chk("t3_one_load_per_byte", n_loads - base, 2);
    chk("t3_dat_byte", 32'(load_log[6'(base + 1)]), 'h44);
    bus.req = '0;

    // T4 command byte never answered -> timeout, then the other requester
    repeat (4) tick();
    chk("t4_rd_before", 32'(bus.rd_data), 'h3E);
    bus.req_cmd = {8'hC1, 8'hC0}; bus.req_data = {8'hD1, 8'hD0};
    rx_val = 8'h69; silent = 1'b1;
    bus.req = 2'b11;
    tick();
    chk("t4_first_gnt", 32'(bus.gnt), 2);
    wait_done(200, n);
    chk("t4_timeout_cycles", n, 65);
    chk("t4_done",     32'(bus.done), 2);
    chk("t4_err",      32'(bus.err), 1);
    chk("t4_rd_zero",  32'(bus.rd_data), 0);
    chk("t4_ssb_high", 32'(bus.m_ssb), 1);
    silent = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.gnt == '0 && k < 20);
    chk("t4_gap_len",  k, 4);
    chk("t4_next_gnt", 32'(bus.gnt), 1);
    wait_done(200, n);
    chk("t4_done2",    32'(bus.done), 1);
    chk("t4_err2",     32'(bus.err), 0);
    chk("t4_rd_data2", 32'(bus.rd_data), 'h69);
    bus.req = '0;

    // T5 reset during the data byte, then m_done on the timeout boundary
    repeat (4) tick();
    bus.req_cmd = {8'h00, 8'h55}; bus.req_data = {8'h00, 8'h66};
    rx_val = 8'h12; base = n_loads;
    bus.req = 2'b01;
    k = 0;
    while (n_loads < base + 2 && k < 50) begin
      tick();
      k++;
    end
    chk("t5_in_data_wait", n_loads - base, 2);
    chk("t5_ssb_low",      32'(bus.m_ssb), 0);
    reset = 1'b1; pulses = n_done;
    tick();
    chk("t5_rst_ssb",  32'(bus.m_ssb), 1);
    chk("t5_rst_gnt",  32'(bus.gnt), 0);
    chk("t5_rst_done", 32'(bus.done), 0);
    chk("t5_rst_err",  32'(bus.err), 0);
    chk("t5_rst_rd",   32'(bus.rd_data), 0);
    reset = 1'b0; bus.req = '0;
    repeat (6) tick();
    chk("t5_no_done_pulse", n_done - pulses, 0);

    bus.req_cmd = {8'h77, 8'h66}; bus.req_data = {8'h99, 8'h88};
    rx_val = 8'h96; lat = 63; base = n_loads;
    bus.req = 2'b11;
    tick();
    chk("t5_ptr_reset_gnt", 32'(bus.gnt), 1);
    wait_done(300, n);
    chk("t5_edge_done", 32'(bus.done), 1);
    chk("t5_edge_err",  32'(bus.err), 0);
    chk("t5_edge_rd",   32'(bus.rd_data), 'h96);
    chk("t5_edge_loads", n_loads - base, 2);
    bus.req = '0;
    repeat (4) tick();
    chk("done_onehot_with_gnt", n_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
